// File: rtl/oled_power_seq_if.sv
// Handshake bundle between the OLED power sequencer and its two helpers:
// the millisecond delay block and the SPI byte sender.
// The master side is the sequencer; the slave side is the delay/SPI pair.
interface oled_power_seq_if;
   logic [11:0] DELAY_MS;
   logic        DELAY_EN;
   logic        DELAY_FIN;
   logic [7:0]  SPI_DATA;
   logic        SPI_EN;
   logic        SPI_FIN;

   modport master (
      output DELAY_MS, DELAY_EN, SPI_DATA, SPI_EN,
      input  DELAY_FIN, SPI_FIN
   );

   modport slave (
      input  DELAY_MS, DELAY_EN, SPI_DATA, SPI_EN,
      output DELAY_FIN, SPI_FIN
   );
endinterface

// File: rtl/oled_power_seq.sv
// OLED panel power-up / init sequencer.
// Brings up VDD, pulses RES, streams the init command bytes over SPI,
// turns on VBAT, then sends the contrast/display-on group and reports FIN.
// Optional build macro OLED_INVERT_EN adds the inverse-display byte (A7)
// directly before display-on (AF).
module oled_power_seq #(
   parameter logic [11:0] T_VDD_MS  = 12'd1,
   parameter logic [11:0] T_RES_MS  = 12'd1,
   parameter logic [11:0] T_VBAT_MS = 12'd100,
   parameter logic [7:0]  CONTRAST  = 8'h0F
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   oled_power_seq_if.master  bus,
   output logic              DC,
   output logic              RES,
   output logic              VDD,
   output logic              VBAT,
   output logic              FIN
);

`ifdef OLED_INVERT_EN
   localparam logic [3:0] NUM_BYTES = 4'd13;
`else
   localparam logic [3:0] NUM_BYTES = 4'd12;
`endif

   typedef enum logic [3:0] {
      IDLE, VDD_ON, WAIT, WAIT_CLR, SEND, SEND_CLR,
      RES_LO, RES_HI, VBAT_ON, DONE
   } state_t;

   state_t      state, state_nxt;
   state_t      ret_state, ret_nxt;
   logic [3:0]  byte_idx, idx_nxt;
   logic [11:0] delay_ms_q, delay_ms_nxt;
   logic        delay_en_q, delay_en_nxt;
   logic [7:0]  spi_data_q, spi_data_nxt;
   logic        spi_en_q, spi_en_nxt;
   logic        res_q, res_nxt;
   logic        vdd_q, vdd_nxt;
   logic        vbat_q, vbat_nxt;
   logic        fin_q, fin_nxt;
   logic [7:0]  table_byte;
   logic        group_end;

   assign bus.DELAY_MS = delay_ms_q;
   assign bus.DELAY_EN = delay_en_q;
   assign bus.SPI_DATA = spi_data_q;
   assign bus.SPI_EN   = spi_en_q;
   assign RES  = res_q;
   assign VDD  = vdd_q;
   assign VBAT = vbat_q;
   assign FIN  = fin_q;
   assign DC   = 1'b0;

   // A group of bytes is finished after AE, after F1, and after the last byte.
   assign group_end = (byte_idx == 4'd1) || (byte_idx == 4'd5) || (byte_idx == NUM_BYTES);

   // Init command table addressed by the running byte index.
   always_comb begin
      table_byte = 8'h00;
      case (byte_idx)
         4'd0:  table_byte = 8'hAE;
         4'd1:  table_byte = 8'h8D;
         4'd2:  table_byte = 8'h14;
         4'd3:  table_byte = 8'hD9;
         4'd4:  table_byte = 8'hF1;
         4'd5:  table_byte = 8'h81;
         4'd6:  table_byte = CONTRAST;
         4'd7:  table_byte = 8'hA0;
         4'd8:  table_byte = 8'hC0;
         4'd9:  table_byte = 8'hDA;
         4'd10: table_byte = 8'h00;
`ifdef OLED_INVERT_EN
         4'd11: table_byte = 8'hA7;
         4'd12: table_byte = 8'hAF;
`else
         4'd11: table_byte = 8'hAF;
`endif
         default: table_byte = 8'h00;
      endcase
   end

   // State register and every registered output; RST low clears all of it.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         ret_state  <= IDLE;
         byte_idx   <= 4'd0;
         delay_ms_q <= 12'd0;
         delay_en_q <= 1'b0;
         spi_data_q <= 8'h00;
         spi_en_q   <= 1'b0;
         res_q      <= 1'b1;
         vdd_q      <= 1'b1;
         vbat_q     <= 1'b1;
         fin_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         ret_state  <= ret_nxt;
         byte_idx   <= idx_nxt;
         delay_ms_q <= delay_ms_nxt;
         delay_en_q <= delay_en_nxt;
         spi_data_q <= spi_data_nxt;
         spi_en_q   <= spi_en_nxt;
         res_q      <= res_nxt;
         vdd_q      <= vdd_nxt;
         vbat_q     <= vbat_nxt;
         fin_q      <= fin_nxt;
      end
   end

   // Next state and next output values; a request is only raised while its FIN is low.
   always_comb begin
      state_nxt    = state;
      ret_nxt      = ret_state;
      idx_nxt      = byte_idx;
      delay_ms_nxt = delay_ms_q;
      delay_en_nxt = delay_en_q;
      spi_data_nxt = spi_data_q;
      spi_en_nxt   = spi_en_q;
      res_nxt      = res_q;
      vdd_nxt      = vdd_q;
      vbat_nxt     = vbat_q;
      fin_nxt      = fin_q;
      case (state)
         IDLE: begin
            fin_nxt = 1'b0;
            if (EN) begin
               idx_nxt   = 4'd0;
               state_nxt = VDD_ON;
            end
         end
         VDD_ON: begin
            vdd_nxt = 1'b0;
            if (!bus.DELAY_FIN) begin
               delay_ms_nxt = T_VDD_MS;
               delay_en_nxt = 1'b1;
               ret_nxt      = SEND;
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            if (bus.DELAY_FIN) begin
               delay_en_nxt = 1'b0;
               state_nxt    = WAIT_CLR;
            end
         end
         WAIT_CLR: begin
            if (!bus.DELAY_FIN) begin
               state_nxt = ret_state;
               if (ret_state == SEND) begin
                  if (byte_idx == 4'd0)
                     ret_nxt = RES_LO;
                  else if (byte_idx == 4'd1)
                     ret_nxt = VBAT_ON;
                  else
                     ret_nxt = DONE;
               end
            end
         end
         SEND: begin
            if (!spi_en_q && !bus.SPI_FIN) begin
               spi_data_nxt = table_byte;
               spi_en_nxt   = 1'b1;
            end else if (spi_en_q && bus.SPI_FIN) begin
               spi_en_nxt = 1'b0;
               idx_nxt    = byte_idx + 4'd1;
               state_nxt  = SEND_CLR;
            end
         end
         SEND_CLR: begin
            if (!bus.SPI_FIN) begin
               if (group_end) begin
                  state_nxt = ret_state;
                  if (ret_state == DONE)
                     fin_nxt = EN;
               end else begin
                  state_nxt = SEND;
               end
            end
         end
         RES_LO: begin
            res_nxt = 1'b0;
            if (!bus.DELAY_FIN) begin
               delay_ms_nxt = T_RES_MS;
               delay_en_nxt = 1'b1;
               ret_nxt      = RES_HI;
               state_nxt    = WAIT;
            end
         end
         RES_HI: begin
            res_nxt = 1'b1;
            if (!bus.DELAY_FIN) begin
               delay_ms_nxt = T_RES_MS;
               delay_en_nxt = 1'b1;
               ret_nxt      = SEND;
               state_nxt    = WAIT;
            end
         end
         VBAT_ON: begin
            vbat_nxt = 1'b0;
            if (!bus.DELAY_FIN) begin
               delay_ms_nxt = T_VBAT_MS;
               delay_en_nxt = 1'b1;
               ret_nxt      = SEND;
               state_nxt    = WAIT;
            end
         end
         DONE: begin
            fin_nxt = EN;
            if (!EN)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
